counter_ctrl: RTL and testbench
===============================

COUNTER_CTRL -- requirements
Module: counter_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter width in bits.
REQ-002 SHALL have parameter DIV_BASE, default 50000000: base tick period in clock cycles (1 Hz at 50 MHz).
REQ-003 SHALL have port clock  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port resetp  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  level; begin or resume counting.
REQ-006 SHALL have port stop  input  1  level; pause counting.
REQ-007 SHALL have port clear  input  1  level; abort and return to IDLE.
REQ-008 SHALL have port one_shot  input  1  1 = halt at limit; 0 = wrap to 0 after limit.
REQ-009 SHALL have port speed  input  2  tick period select.
REQ-010 SHALL have port limit  input  WIDTH  terminal count value.
REQ-011 SHALL have port q  output  WIDTH  count value, registered.
REQ-012 SHALL have port tick  output  1  one-cycle pulse, high in the cycle after q updates.
REQ-013 SHALL have port running  output  1  high only in state RUN.
REQ-014 SHALL have port done  output  1  high only in state DONE.

Function
REQ-015 SHALL implement the states IDLE, RUN, PAUSE and DONE.
REQ-016 SHALL select the period P from speed as: 00 -> 1; 01 -> DIV_BASE; 10 -> 2*DIV_BASE; 11 -> 4*DIV_BASE cycles.
REQ-017 SHALL size the divider down-counter to hold 4*DIV_BASE-1 (clog2 width), with no truncation.
REQ-018 SHALL apply input priority on every edge as clear > stop > start.
REQ-019 SHALL, on clear in any state: go to IDLE, set q=0, reload divider with P-1.
REQ-020 SHALL, in IDLE: hold q=0, hold divider at P-1 (tracks speed), go to RUN on start.
REQ-021 SHALL, in RUN: decrement the divider each cycle; when it is 0, reload it with P-1 (speed sampled at reload) and advance q.
REQ-022 SHALL advance q as follows: if q != limit then q+1; if q == limit and one_shot=0 then q=0; if q == limit and one_shot=1 then q unchanged, no tick, and go to DONE.
REQ-023 SHALL make the first q update occur exactly P edges after the edge that samples start in IDLE; subsequent updates every P cycles.
REQ-024 SHALL, in RUN with stop: go to PAUSE with divider and q frozen; start in PAUSE returns to RUN resuming from the frozen divider value.
REQ-025 SHALL, in DONE: hold q=limit-as-reached and done=1; start -> RUN with q=0 and divider=P-1.
REQ-026 SHALL, with limit=0: in wrap mode hold q at 0 and tick every P cycles; in one-shot mode go to DONE at the first divider expiry.
REQ-027 SHALL compare against the current limit every update; if q > limit, q counts up and wraps naturally at 2^WIDTH-1 -> 0, then compares normally.
REQ-028 SHALL treat start and stop high together in RUN as stop (PAUSE); in PAUSE as stop (remain PAUSE).

Reset
REQ-029 SHALL, with resetp high at an edge, set state=IDLE, q=0, tick=0, running=0, done=0, divider=P-1, overriding all other inputs.
REQ-030 SHALL, when resetp is asserted mid-RUN, discard the partial divider count; the next start restarts timing from full P.

Structure
REQ-031 SHALL take the state encoding (2-bit) and the speed codes from shared package counter_ctrl_pkg.
REQ-032 SHALL place the period-select and down-counter in one sub-module, rate_divider (inputs: clock, resetp, load, en, speed; output: expire).
REQ-033 SHALL keep the FSM and q register in counter_ctrl; all outputs registered, no combinational input-to-output paths.

Verification (bench uses WIDTH=4, DIV_BASE=3)
REQ-034 SHALL cover: speed=01, limit=5, one_shot=0, start pulse -> q=1 at 3 edges after start, then 2,3,4,5,0,1 every 3 cycles, one tick per update.
REQ-035 SHALL cover: speed=00, limit=3, one_shot=1 -> q=1,2,3 on consecutive edges, then DONE, done=1, q holds 3, no 4th tick; start -> q=0, RUN.
REQ-036 SHALL cover: speed=10, stop asserted 2 cycles into a 6-cycle period, held 10 cycles, then start -> next q update exactly 4 cycles after resume.
REQ-037 SHALL cover: start+stop+clear high together in RUN with q=7 -> IDLE, q=0, running=0 next edge.
REQ-038 SHALL cover: limit lowered from 9 to 2 while q=6, wrap mode -> q runs 7..15,0,1,2,0.
REQ-039 SHALL cover: resetp pulse mid-RUN (q=4, divider mid-count) -> all outputs 0 next edge; restart gives first update P edges after start.

Source files
------------

// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : counter_ctrl_pkg
//  Purpose  : Shared state encoding, speed codes and period helpers for the
//             counter controller and its rate divider.
//  Revision : 1.0  initial release
// ============================================================================
package counter_ctrl_pkg;

    // Controller state encoding (2-bit)
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_RUN   = 2'd1;
    localparam logic [1:0] c_ST_PAUSE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    typedef logic [1:0] state_t;

    // Speed codes: tick period multiplier applied to the base period
    localparam logic [1:0] c_SPD_FAST = 2'b00;  // every clock
    localparam logic [1:0] c_SPD_X1   = 2'b01;  // 1 x base
    localparam logic [1:0] c_SPD_X2   = 2'b10;  // 2 x base
    localparam logic [1:0] c_SPD_X4   = 2'b11;  // 4 x base

    // Reload value (period minus one) for a given speed code
    function automatic int unsigned period_m1(input logic [1:0] spd,
                                              input int unsigned base);
        case (spd)
            c_SPD_FAST: return 0;
            c_SPD_X1:   return base - 1;
            c_SPD_X2:   return 2 * base - 1;
            default:    return 4 * base - 1;
        endcase
    endfunction

    // Down-counter width able to hold the longest reload value
    function automatic int unsigned div_width(input int unsigned base);
        return (4 * base > 1) ? $clog2(4 * base) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rate_divider.sv
`default_nettype none
// ============================================================================
//  Module   : rate_divider
//  Purpose  : Period select plus down-counter. Counts down while enabled and
//             flags expiry when the count is zero, reloading P-1 from the
//             speed code sampled at that moment.
//  Revision : 1.0  initial release
// ============================================================================
module rate_divider
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned DIV_BASE = 50000000
) (
    input  logic       clock,
    input  logic       resetp,
    input  logic       load,
    input  logic       en,
    input  logic [1:0] speed,
    output logic       expire
);

    localparam int unsigned c_DIV_W = div_width(DIV_BASE);

    logic [c_DIV_W-1:0] r_cnt;
    logic [c_DIV_W-1:0] w_reload;
    logic               w_zero;

    assign w_reload = c_DIV_W'(period_m1(speed, DIV_BASE));
    assign w_zero   = (r_cnt == '0);
    assign expire   = en & w_zero;

    // Reload on reset, explicit load or expiry; otherwise count down when enabled
    always_ff @(posedge clock) begin
        if (resetp || load || (en && w_zero)) begin
            r_cnt <= w_reload;
        end else if (en) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : counter_ctrl
//  Purpose  : Start/stop/clear controlled up-counter with selectable tick
//             period, wrap or one-shot terminal behaviour. All outputs are
//             registered.
//  Revision : 1.0  initial release
// ============================================================================
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int          WIDTH    = 4,
    parameter int unsigned DIV_BASE = 50000000
) (
    input  logic             clock,
    input  logic             resetp,
    input  logic             start,
    input  logic             stop,
    input  logic             clear,
    input  logic             one_shot,
    input  logic [1:0]       speed,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             tick,
    output logic             running,
    output logic             done
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_running;
    logic             r_done;
    logic             w_go;
    logic             w_at_limit;
    logic             w_div_en;
    logic             w_div_load;
    logic             w_expire;

    // stop outranks start, so a start only counts while stop is low
    assign w_go       = start & ~stop;
    assign w_at_limit = (r_q == limit);
    // Divider runs only in RUN when neither clear nor stop is pending
    assign w_div_en   = (r_state == c_ST_RUN) & ~clear & ~stop;
    // Outside RUN/PAUSE the divider sits at P-1, tracking the speed input
    assign w_div_load = clear | (r_state == c_ST_IDLE) | (r_state == c_ST_DONE);

    rate_divider #(
        .DIV_BASE (DIV_BASE)
    ) u_rate_divider (
        .clock  (clock),
        .resetp (resetp),
        .load   (w_div_load),
        .en     (w_div_en),
        .speed  (speed),
        .expire (w_expire)
    );

    // State register
    always_ff @(posedge clock) begin
        if (resetp) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, priority clear > stop > start
    always_comb begin
        w_state_nxt = r_state;
        if (clear) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_go) w_state_nxt = c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (stop) begin
                        w_state_nxt = c_ST_PAUSE;
                    end else if (w_expire && w_at_limit && one_shot) begin
                        w_state_nxt = c_ST_DONE;
                    end
                end
                c_ST_PAUSE: begin
                    if (w_go) w_state_nxt = c_ST_RUN;
                end
                c_ST_DONE: begin
                    if (w_go) w_state_nxt = c_ST_RUN;
                end
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Count and tick decisions; q only moves on a divider expiry in RUN
    always_comb begin
        w_q_nxt    = r_q;
        w_tick_nxt = 1'b0;
        if (clear) begin
            w_q_nxt = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: w_q_nxt = '0;
                c_ST_RUN: begin
                    if (w_expire) begin
                        if (!w_at_limit) begin
                            // Also covers q above limit: natural wrap at 2^WIDTH
                            w_q_nxt    = r_q + 1'b1;
                            w_tick_nxt = 1'b1;
                        end else if (!one_shot) begin
                            w_q_nxt    = '0;
                            w_tick_nxt = 1'b1;
                        end
                    end
                end
                c_ST_DONE: begin
                    if (w_go) w_q_nxt = '0;
                end
                default: ;
            endcase
        end
    end

    // Output registers; status flags follow the state being entered
    always_ff @(posedge clock) begin
        if (resetp) begin
            r_q       <= '0;
            r_tick    <= 1'b0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_q       <= w_q_nxt;
            r_tick    <= w_tick_nxt;
            r_running <= (w_state_nxt == c_ST_RUN);
            r_done    <= (w_state_nxt == c_ST_DONE);
        end
    end

    assign q       = r_q;
    assign tick    = r_tick;
    assign running = r_running;
    assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_counter_ctrl
//  Purpose  : Self-checking bench for counter_ctrl (WIDTH=4, DIV_BASE=3)
//             using directed scenarios and a behavioural reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_counter_ctrl;

    localparam int WIDTH    = 4;
    localparam int DIV_BASE = 3;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic             clock = 1'b0;
    logic             resetp;
    logic             start;
    logic             stop;
    logic             clear;
    logic             one_shot;
    logic [1:0]       speed;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             running;
    logic             done;

    int checks = 0;
    int errors = 0;

    // Reference model: state, count, tick, and edges left until the next update
    int               m_st   = M_IDLE;
    logic [WIDTH-1:0] m_q    = '0;
    logic             m_tick = 1'b0;
    int               m_rem  = 1;

    counter_ctrl #(
        .WIDTH    (WIDTH),
        .DIV_BASE (DIV_BASE)
    ) dut (
        .clock    (clock),
        .resetp   (resetp),
        .start    (start),
        .stop     (stop),
        .clear    (clear),
        .one_shot (one_shot),
        .speed    (speed),
        .limit    (limit),
        .q        (q),
        .tick     (tick),
        .running  (running),
        .done     (done)
    );

    always #5 clock = ~clock;

    function automatic int period(input logic [1:0] s);
        case (s)
            2'b00:   return 1;
            2'b01:   return DIV_BASE;
            2'b10:   return 2 * DIV_BASE;
            default: return 4 * DIV_BASE;
        endcase
    endfunction

    // Advance the model by one edge from the current inputs, then clock the DUT
    task automatic step();
        int p;
        p      = period(speed);
        m_tick = 1'b0;
        if (resetp || clear) begin
            m_st  = M_IDLE;
            m_q   = '0;
            m_rem = p;
        end else begin
            case (m_st)
                M_IDLE: begin
                    m_q   = '0;
                    m_rem = p;
                    if (start && !stop) m_st = M_RUN;
                end
                M_RUN: begin
                    if (stop) begin
                        m_st = M_PAUSE;
                    end else begin
                        m_rem = m_rem - 1;
                        if (m_rem == 0) begin
                            m_rem = p;
                            if (m_q != limit) begin
                                m_q    = m_q + 1'b1;
                                m_tick = 1'b1;
                            end else if (!one_shot) begin
                                m_q    = '0;
                                m_tick = 1'b1;
                            end else begin
                                m_st = M_DONE;
                            end
                        end
                    end
                end
                M_PAUSE: begin
                    if (start && !stop) m_st = M_RUN;
                end
                default: begin
                    m_rem = p;
                    if (start && !stop) begin
                        m_st = M_RUN;
                        m_q  = '0;
                    end
                end
            endcase
        end
        @(posedge clock);
        #1;
    endtask

    task automatic go_idle();
        resetp = 1'b0; stop = 1'b0; start = 1'b0;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        resetp = 1'b1; start = 1'b1; stop = 1'b0; clear = 1'b0;
        one_shot = 1'b0; speed = 2'b01; limit = 4'd5;
        step();
        step();
        checks++;
        if ({q, tick, running, done} !== 7'd0) begin
            errors++;
            $display("FAIL reset: got q=%0d tick=%0b run=%0b done=%0b, want all 0", q, tick, running, done);
        end
        resetp = 1'b0; start = 1'b0;
        step();
        checks++;
        if ({q, tick, running, done} !== 7'd0) begin
            errors++;
            $display("FAIL reset_idle: got q=%0d tick=%0b run=%0b done=%0b, want all 0", q, tick, running, done);
        end
    endtask

    // speed=01, limit=5, wrap: updates every 3 edges giving 1,2,3,4,5,0,1
    task automatic test_wrap();
        int exp_seq [7] = '{1, 2, 3, 4, 5, 0, 1};
        int n = 0;
        go_idle();
        speed = 2'b01; limit = 4'd5; one_shot = 1'b0;
        pulse_start();
        checks++;
        if (running !== 1'b1 || q !== 4'd0) begin
            errors++;
            $display("FAIL wrap_start: got run=%0b q=%0d, want run=1 q=0", running, q);
        end
        for (int c = 1; c <= 21; c++) begin
            step();
            if (tick === 1'b1) begin
                checks++;
                if (n >= 7 || c != 3 * (n + 1) || q !== 4'(exp_seq[n])) begin
                    errors++;
                    $display("FAIL wrap_tick: edge %0d tick#%0d got q=%0d, want edge %0d q=%0d",
                             c, n, q, 3 * (n + 1), (n < 7) ? exp_seq[n] : -1);
                end
                n++;
            end
        end
        checks++;
        if (n != 7) begin
            errors++;
            $display("FAIL wrap_count: got %0d ticks, want 7", n);
        end
    endtask

    // speed=00, limit=3, one-shot: 1,2,3 back to back, then DONE holding 3
    task automatic test_one_shot();
        go_idle();
        speed = 2'b00; limit = 4'd3; one_shot = 1'b1;
        pulse_start();
        for (int c = 1; c <= 3; c++) begin
            step();
            checks++;
            if (q !== 4'(c) || tick !== 1'b1 || running !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_count: edge %0d got q=%0d tick=%0b run=%0b, want q=%0d tick=1 run=1",
                         c, q, tick, running, c);
            end
        end
        for (int c = 4; c <= 7; c++) begin
            step();
            checks++;
            if (q !== 4'd3 || tick !== 1'b0 || running !== 1'b0 || done !== 1'b1) begin
                errors++;
                $display("FAIL oneshot_done: edge %0d got q=%0d tick=%0b run=%0b done=%0b, want q=3 tick=0 run=0 done=1",
                         c, q, tick, running, done);
            end
        end
        pulse_start();
        checks++;
        if (q !== 4'd0 || running !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL oneshot_restart: got q=%0d run=%0b done=%0b, want q=0 run=1 done=0", q, running, done);
        end
    endtask

    // speed=10 (P=6): pause two edges into a period, resume 4 edges from update
    task automatic test_pause();
        logic [WIDTH-1:0] q_frz;
        int               seen = 0;
        go_idle();
        speed = 2'b10; limit = 4'd15; one_shot = 1'b0;
        pulse_start();
        for (int c = 0; c < 20 && seen == 0; c++) begin
            step();
            if (tick === 1'b1) seen = 1;
        end
        checks++;
        if (seen == 0) begin
            errors++;
            $display("FAIL pause_first_tick: got no tick within 20 edges, want one");
        end
        step();
        step();
        q_frz = q;
        stop  = 1'b1;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (running !== 1'b0 || tick !== 1'b0 || q !== q_frz) begin
                errors++;
                $display("FAIL pause_hold: edge %0d got run=%0b tick=%0b q=%0d, want run=0 tick=0 q=%0d",
                         c, running, tick, q, q_frz);
            end
        end
        stop = 1'b0;
        pulse_start();
        seen = 0;
        for (int c = 1; c <= 10 && seen == 0; c++) begin
            step();
            if (tick === 1'b1) seen = c;
        end
        checks++;
        if (seen != 4 || q !== q_frz + 1'b1) begin
            errors++;
            $display("FAIL pause_resume: got update after %0d edges q=%0d, want 4 edges q=%0d",
                     seen, q, q_frz + 1'b1);
        end
    endtask

    // start+stop+clear together in RUN with q=7 aborts to IDLE
    task automatic test_abort();
        go_idle();
        speed = 2'b00; limit = 4'd15; one_shot = 1'b0;
        pulse_start();
        for (int c = 0; c < 20 && q !== 4'd7; c++) step();
        checks++;
        if (q !== 4'd7 || running !== 1'b1) begin
            errors++;
            $display("FAIL abort_setup: got q=%0d run=%0b, want q=7 run=1", q, running);
        end
        start = 1'b1; stop = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; stop = 1'b0; clear = 1'b0;
        checks++;
        if ({q, tick, running, done} !== 7'd0) begin
            errors++;
            $display("FAIL abort: got q=%0d tick=%0b run=%0b done=%0b, want all 0", q, tick, running, done);
        end
    endtask

    // limit dropped from 9 to 2 at q=6: 7..15,0,1,2,0
    task automatic test_limit_change();
        int exp_seq [13] = '{7, 8, 9, 10, 11, 12, 13, 14, 15, 0, 1, 2, 0};
        int n = 0;
        go_idle();
        speed = 2'b00; limit = 4'd9; one_shot = 1'b0;
        pulse_start();
        for (int c = 0; c < 20 && q !== 4'd6; c++) step();
        limit = 4'd2;
        for (int c = 0; c < 30 && n < 13; c++) begin
            step();
            if (tick === 1'b1) begin
                checks++;
                if (q !== 4'(exp_seq[n])) begin
                    errors++;
                    $display("FAIL limit_change: update %0d got q=%0d, want %0d", n, q, exp_seq[n]);
                end
                n++;
            end
        end
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL limit_change_count: got %0d updates, want 13", n);
        end
    endtask

    // reset mid-count discards partial divider; restart takes full P
    task automatic test_reset_mid();
        int seen = 0;
        go_idle();
        speed = 2'b01; limit = 4'd15; one_shot = 1'b0;
        pulse_start();
        for (int c = 0; c < 30 && q !== 4'd4; c++) step();
        step();
        resetp = 1'b1;
        step();
        resetp = 1'b0;
        checks++;
        if ({q, tick, running, done} !== 7'd0) begin
            errors++;
            $display("FAIL reset_mid: got q=%0d tick=%0b run=%0b done=%0b, want all 0", q, tick, running, done);
        end
        step();
        pulse_start();
        for (int c = 1; c <= 10 && seen == 0; c++) begin
            step();
            if (tick === 1'b1) seen = c;
        end
        checks++;
        if (seen != 3 || q !== 4'd1) begin
            errors++;
            $display("FAIL reset_restart: got update after %0d edges q=%0d, want 3 edges q=1", seen, q);
        end
    endtask

    // Random control traffic checked cycle by cycle against the model
    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            resetp = ($urandom_range(99) == 0);
            clear  = ($urandom_range(49) == 0);
            stop   = ($urandom_range(9) == 0);
            start  = ($urandom_range(3) == 0);
            if ($urandom_range(39) == 0)
                speed = ($urandom_range(3) == 0) ? 2'($urandom_range(3)) : 2'($urandom_range(1));
            if ($urandom_range(29) == 0) limit    = 4'($urandom_range(15));
            if ($urandom_range(59) == 0) one_shot = 1'($urandom_range(1));
            step();
            checks++;
            if ({q, tick, running, done} !== {m_q, m_tick, (m_st == M_RUN), (m_st == M_DONE)}) begin
                errors++;
                $display("FAIL random: cycle %0d got q=%0d tick=%0b run=%0b done=%0b, want q=%0d tick=%0b run=%0b done=%0b",
                         c, q, tick, running, done, m_q, m_tick, (m_st == M_RUN), (m_st == M_DONE));
            end
        end
    endtask

    initial begin
        resetp = 1'b1; start = 1'b0; stop = 1'b0; clear = 1'b0;
        one_shot = 1'b0; speed = 2'b00; limit = '0;
        test_reset();
        test_wrap();
        test_one_shot();
        test_pause();
        test_abort();
        test_limit_change();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
